// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//   Wishbone B3 classic bus master fed by a valid/ready command stream.
//   Commands are buffered in a small FIFO and issued one at a time; every
//   command produces exactly one status-tagged response, in command order.
//   A transaction terminated by rty is re-issued after a one-cycle backoff,
//   up to RETRY_MAX times. A transaction that sees no termination for
//   TIMEOUT cycles is abandoned.
//
// Ports
//   clk_tb, reset_tb      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_we/adr/dat/sel    command payload (write flag, address, data, byte sel)
//   rsp_valid/rsp_ready   response handshake
//   rsp_dat               read data (0 for writes and failed transactions)
//   rsp_status            00 ok, 01 err, 10 retry exhausted, 11 timeout
//   busy                  FIFO non-empty or a command still in progress
//   wb_*_o / wb_*_i       Wishbone master interface
// ---------------------------------------------------------------------------
module wb_cmd_master #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int DEPTH     = 4,
  parameter int RETRY_MAX = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk_tb,
  input  logic              reset_tb,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AW-1:0]     cmd_adr,
  input  logic [DW-1:0]     cmd_dat,
  input  logic [DW/8-1:0]   cmd_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_dat,
  output logic [1:0]        rsp_status,
  output logic              busy,
  output logic [AW-1:0]     wb_adr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_rty_i
);

  localparam int SW = DW / 8;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int EW = 1 + AW + DW + SW;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT - 1);

  localparam logic [1:0] STAT_OK    = 2'b00;
  localparam logic [1:0] STAT_ERR   = 2'b01;
  localparam logic [1:0] STAT_RETRY = 2'b10;
  localparam logic [1:0] STAT_TMO   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t          state_r;
  logic [EW-1:0]   fifo_mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            ready_r;
  logic [RW-1:0]   retry_cnt_r;
  logic [TW-1:0]   to_cnt_r;

  logic            push_s;
  logic            pop_s;
  logic [CW-1:0]   count_next_s;
  logic [EW-1:0]   head_s;

  // ready_r is a registered copy of "not full", so it reads 0 during reset
  assign cmd_ready = ready_r;
  assign busy      = (count_r != {CW{1'b0}}) || (state_r != ST_IDLE);

  assign push_s = cmd_valid && ready_r;
  // The FSM only ever takes a command while idle
  assign pop_s  = (state_r == ST_IDLE) && (count_r != {CW{1'b0}});
  assign head_s = fifo_mem_r[rd_ptr_r];

  // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CW'(1);
    end else if (!push_s && pop_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // FIFO storage (payload only, no reset needed)
  always_ff @(posedge clk_tb) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {cmd_we, cmd_adr, cmd_dat, cmd_sel};
    end
  end

  // FIFO pointers, occupancy and the registered ready flag
  always_ff @(posedge clk_tb or negedge reset_tb) begin
    if (!reset_tb) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      ready_r  <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_next_s;
      ready_r <= (count_next_s != FULL_CNT);
    end
  end

  // Transaction FSM with registered bus and response outputs
  always_ff @(posedge clk_tb or negedge reset_tb) begin
    if (!reset_tb) begin
      state_r     <= ST_IDLE;
      retry_cnt_r <= {RW{1'b0}};
      to_cnt_r    <= {TW{1'b0}};
      wb_adr_o    <= {AW{1'b0}};
      wb_dat_o    <= {DW{1'b0}};
      wb_sel_o    <= {SW{1'b0}};
      wb_we_o     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_dat     <= {DW{1'b0}};
      rsp_status  <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            {wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} <= head_s;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            retry_cnt_r <= {RW{1'b0}};
            to_cnt_r    <= {TW{1'b0}};
            state_r     <= ST_BUS;
          end
        end

        ST_BUS: begin
          // Termination priority: err over ack over rty
          if (wb_err_i) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            rsp_dat    <= {DW{1'b0}};
            rsp_status <= STAT_ERR;
            rsp_valid  <= 1'b1;
            state_r    <= ST_RESP;
          end else if (wb_ack_i) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            rsp_dat    <= wb_we_o ? {DW{1'b0}} : wb_dat_i;
            rsp_status <= STAT_OK;
            rsp_valid  <= 1'b1;
            state_r    <= ST_RESP;
          end else if (wb_rty_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (retry_cnt_r < RETRY_LIM) begin
              retry_cnt_r <= retry_cnt_r + RW'(1);
              state_r     <= ST_BACKOFF;
            end else begin
              rsp_dat    <= {DW{1'b0}};
              rsp_status <= STAT_RETRY;
              rsp_valid  <= 1'b1;
              state_r    <= ST_RESP;
            end
          end else if (to_cnt_r == TO_LIM) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            rsp_dat    <= {DW{1'b0}};
            rsp_status <= STAT_TMO;
            rsp_valid  <= 1'b1;
            state_r    <= ST_RESP;
          end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
          end
        end

        ST_BACKOFF: begin
          // wb_adr/dat/sel/we were never touched, so the reissue is identical
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          to_cnt_r <= {TW{1'b0}};
          state_r  <= ST_BUS;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_dat    <= {DW{1'b0}};
            rsp_status <= 2'b00;
            state_r    <= ST_IDLE;
          end
        end

        default: begin
          wb_cyc_o  <= 1'b0;
          wb_stb_o  <= 1'b0;
          rsp_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wb_cmd_master
//   Directed self-checking bench for wb_cmd_master with default parameters
//   (AW=32, DW=32, DEPTH=4, RETRY_MAX=3, TIMEOUT=64). The slave side is
//   driven cycle by cycle from the main sequence; all expected values are
//   hand-computed constants.
// ---------------------------------------------------------------------------
module tb_wb_cmd_master;

  logic        clk_tb;
  logic        reset_tb;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;

  int errors = 0;
  int checks = 0;

  wb_cmd_master #(
    .AW(32), .DW(32), .DEPTH(4), .RETRY_MAX(3), .TIMEOUT(64)
  ) dut (
    .clk_tb(clk_tb), .reset_tb(reset_tb),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_status(rsp_status), .busy(busy),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_gone"}, {63'd0, rsp_valid}, 64'd0);
  endtask

  task automatic wait_stb(input string tag);
    int n = 0;
    while (wb_stb_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_stb_seen"}, {63'd0, wb_stb_o}, 64'd1);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_rsp_seen"}, {63'd0, rsp_valid}, 64'd1);
  endtask

  initial begin
    int n;
    reset_tb  = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = 32'd0;
    cmd_dat   = 32'd0;
    cmd_sel   = 4'd0;
    rsp_ready = 1'b0;
    wb_dat_i  = 32'd0;
    wb_ack_i  = 1'b0;
    wb_err_i  = 1'b0;
    wb_rty_i  = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
    chk("rst_stb", {63'd0, wb_stb_o}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    reset_tb = 1'b1;
    tick();
    chk("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // stray ack while idle must not create a response
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("idle_ack_ignored", {63'd0, rsp_valid}, 64'd0);

    // ---------------- 1: zero-wait write ----------------
    send_cmd(1'b1, 32'h0000_0003, 32'h0000_0003, 4'hF);   // E0
    chk("t1_cyc_E0", {63'd0, wb_cyc_o}, 64'd0);
    chk("t1_busy_E0", {63'd0, busy}, 64'd1);
    tick();                                                // E1
    chk("t1_cyc_E1", {63'd0, wb_cyc_o}, 64'd1);
    chk("t1_stb_E1", {63'd0, wb_stb_o}, 64'd1);
    chk("t1_adr", {32'd0, wb_adr_o}, 64'h3);
    chk("t1_dat", {32'd0, wb_dat_o}, 64'h3);
    chk("t1_sel", {60'd0, wb_sel_o}, 64'hF);
    chk("t1_we", {63'd0, wb_we_o}, 64'd1);
    wb_ack_i = 1'b1;
    tick();                                                // E2
    wb_ack_i = 1'b0;
    chk("t1_cyc_E2", {63'd0, wb_cyc_o}, 64'd0);
    chk("t1_rsp_valid_E2", {63'd0, rsp_valid}, 64'd1);
    chk("t1_status", {62'd0, rsp_status}, 64'd0);
    chk("t1_rsp_dat", {32'd0, rsp_dat}, 64'd0);
    consume("t1");

    // ---------------- 2: read with 3 wait states ----------------
    send_cmd(1'b0, 32'h0000_0005, 32'h0, 4'hF);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_stb_held", {63'd0, wb_stb_o}, 64'd1);
      chk("t2_adr_stable", {32'd0, wb_adr_o}, 64'h5);
      if (i == 3) begin
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0000_0060;
      end
      tick();
    end
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    chk("t2_cyc_drop", {63'd0, wb_cyc_o}, 64'd0);
    chk("t2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t2_rsp_dat", {32'd0, rsp_dat}, 64'h60);
    chk("t2_status", {62'd0, rsp_status}, 64'd0);
    consume("t2");

    // ---------------- 3a: 3 rty then ack ----------------
    send_cmd(1'b1, 32'h0000_0010, 32'h0000_00AA, 4'hF);
    tick();
    for (int a = 0; a < 4; a++) begin
      chk("t3a_stb_pulse", {63'd0, wb_stb_o}, 64'd1);
      chk("t3a_adr", {32'd0, wb_adr_o}, 64'h10);
      if (a < 3) wb_rty_i = 1'b1;
      else       wb_ack_i = 1'b1;
      tick();
      wb_rty_i = 1'b0;
      wb_ack_i = 1'b0;
      if (a < 3) begin
        chk("t3a_backoff_cyc", {63'd0, wb_cyc_o}, 64'd0);
        chk("t3a_backoff_no_rsp", {63'd0, rsp_valid}, 64'd0);
        tick();
      end
    end
    chk("t3a_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t3a_status", {62'd0, rsp_status}, 64'd0);
    consume("t3a");

    // ---------------- 3b: 4 rty -> retry exhausted ----------------
    send_cmd(1'b0, 32'h0000_0011, 32'h0, 4'hF);
    tick();
    for (int a = 0; a < 4; a++) begin
      chk("t3b_stb_pulse", {63'd0, wb_stb_o}, 64'd1);
      wb_rty_i = 1'b1;
      wb_dat_i = 32'h0000_BEEF;
      tick();
      wb_rty_i = 1'b0;
      chk("t3b_cyc_low", {63'd0, wb_cyc_o}, 64'd0);
      if (a < 3) begin
        chk("t3b_no_rsp_yet", {63'd0, rsp_valid}, 64'd0);
        tick();
      end
    end
    wb_dat_i = 32'h0;
    chk("t3b_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t3b_status", {62'd0, rsp_status}, 64'd2);
    chk("t3b_rsp_dat", {32'd0, rsp_dat}, 64'd0);
    consume("t3b");

    // ---------------- 4: timeout, then ack+err together ----------------
    send_cmd(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    tick();
    n = 0;
    while (wb_cyc_o === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("t4_bus_cycles", 64'(n), 64'd64);
    chk("t4_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t4_status", {62'd0, rsp_status}, 64'd3);
    consume("t4");

    send_cmd(1'b0, 32'h0000_0044, 32'h0, 4'hF);
    tick();
    chk("t4b_stb", {63'd0, wb_stb_o}, 64'd1);
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    wb_dat_i = 32'h0000_DEAD;
    tick();
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 32'h0;
    chk("t4b_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t4b_status", {62'd0, rsp_status}, 64'd1);
    chk("t4b_rsp_dat", {32'd0, rsp_dat}, 64'd0);
    consume("t4b");

    // ---------------- 5: fill FIFO, stall response, drain in order ------
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_sel   = 4'hF;
    cmd_dat   = 32'h0;
    cmd_adr   = 32'h20;
    tick();                      // c0 pushed
    for (int k = 1; k < 5; k++) begin
      cmd_adr = 32'h20 + 32'(k);
      chk("t5_ready_before_full", {63'd0, cmd_ready}, 64'd1);
      tick();                    // c0 popped on first edge, c1..c4 queued
    end
    chk("t5_full", {63'd0, cmd_ready}, 64'd0);
    cmd_adr = 32'h25;            // must not be accepted
    tick();
    chk("t5_still_full", {63'd0, cmd_ready}, 64'd0);
    cmd_valid = 1'b0;
    chk("t5_c0_adr", {32'd0, wb_adr_o}, 64'h20);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h100;
    tick();
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    tick();
    tick();
    chk("t5_stall_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t5_stall_dat", {32'd0, rsp_dat}, 64'h100);
    chk("t5_stall_cyc", {63'd0, wb_cyc_o}, 64'd0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        wait_stb("t5");
        chk("t5_order_adr", {32'd0, wb_adr_o}, 64'h20 + 64'(k));
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h100 + 32'(k);
        tick();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
      end
      wait_rsp("t5");
      chk("t5_order_dat", {32'd0, rsp_dat}, 64'h100 + 64'(k));
      tick();
    end
    rsp_ready = 1'b0;
    chk("t5_drained_busy", {63'd0, busy}, 64'd0);
    chk("t5_drained_ready", {63'd0, cmd_ready}, 64'd1);

    // ---------------- 6: reset mid-transaction ----------------
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_dat   = 32'h55;
    for (int k = 0; k < 3; k++) begin
      cmd_adr = 32'h30 + 32'(k);
      tick();
    end
    cmd_valid = 1'b0;
    chk("t6_stb_before", {63'd0, wb_stb_o}, 64'd1);
    chk("t6_busy_before", {63'd0, busy}, 64'd1);
    reset_tb = 1'b0;
    #1;
    chk("t6_cyc_async", {63'd0, wb_cyc_o}, 64'd0);
    chk("t6_stb_async", {63'd0, wb_stb_o}, 64'd0);
    tick();
    reset_tb = 1'b1;
    tick();
    chk("t6_busy_after", {63'd0, busy}, 64'd0);
    chk("t6_rsp_valid_after", {63'd0, rsp_valid}, 64'd0);
    chk("t6_cmd_ready_after", {63'd0, cmd_ready}, 64'd1);
    tick();
    tick();
    tick();
    chk("t6_queue_discarded", {63'd0, wb_cyc_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
